// File: rtl/emg_pkg.sv
// emg_pkg: shared definitions for the multichannel EMG synthesizer.
//   - default widths (channels, spike-count, sample, accumulator)
//   - frame-sequencer state encoding
//   - signed saturation helper used by the output formatter
package emg_pkg;

    localparam int EMG_NCH = 4;
    localparam int EMG_CW  = 9;
    localparam int EMG_DW  = 18;
    localparam int EMG_AW  = 36;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } emg_state_e;

    // Clamp a signed value into the range of a dw-bit signed number.
    // The caller detects clipping by comparing the result with the input.
    function automatic logic signed [63:0] emg_sat(input logic signed [63:0] v,
                                                   input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            emg_sat = hi;
        end else if (v < lo) begin
            emg_sat = lo;
        end else begin
            emg_sat = v;
        end
    endfunction

endpackage

// File: rtl/emg_filter_core.sv
// emg_filter_core: single-channel, purely combinational filter step.
// Produces next low-pass/high-pass states and the band-passed sample
// e = lp' - hp' from one spike count and the current filter state.
// Ports:
//   cnt_i     unsigned spike count
//   lp_i/hp_i current low-pass / high-pass state (signed AW)
//   gain_i    stimulus scale, stim = cnt << gain
//   ls_i/hs_i low-pass / high-pass coefficient shifts (0 is legal)
//   lp_o/hp_o next filter states
//   e_o       unformatted sample (signed AW)
module emg_filter_core
    import emg_pkg::*;
#(
    parameter int CW = EMG_CW,
    parameter int AW = EMG_AW
) (
    input  logic [CW-1:0]        cnt_i,
    input  logic signed [AW-1:0] lp_i,
    input  logic signed [AW-1:0] hp_i,
    input  logic [3:0]           gain_i,
    input  logic [2:0]           ls_i,
    input  logic [3:0]           hs_i,
    output logic signed [AW-1:0] lp_o,
    output logic signed [AW-1:0] hp_o,
    output logic signed [AW-1:0] e_o
);

    logic signed [AW-1:0] stim;

    assign stim = $signed({{(AW-CW){1'b0}}, cnt_i}) << gain_i;

    // With a zero shift both filters collapse to the stimulus itself.
    assign hp_o = hp_i + (stim >>> hs_i) - (hp_i >>> hs_i);
    assign lp_o = lp_i - (lp_i >>> ls_i) + (stim >>> ls_i);
    assign e_o  = lp_o - hp_o;

endmodule

// File: rtl/emg_bank.sv
// emg_bank: time-multiplexed multichannel surface-EMG synthesizer.
// One frame = capture, NCH filter steps (one channel per cycle), publish.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   i_spk_cnt         packed unsigned counts, channel k at [k*CW +: CW]
//   i_valid           frame strobe
//   i_gain_shift, i_lp_shift, i_hp_shift, i_sat_en   per-frame settings
//   emg_out           packed signed samples, channel k at [k*DW +: DW]
//   o_valid           one-cycle pulse, emg_out/o_sat fresh this cycle
//   o_busy            frame in progress
//   o_sat             per-channel clip flags of the last frame
//   o_overrun         sticky: a strobe arrived while busy
//
// Handshake: i_valid is a one-cycle strobe with no back-pressure. It is
// accepted only in IDLE; counts and settings are sampled on that same
// cycle. A strobe while o_busy is dropped and sets o_overrun. o_valid is
// a one-cycle pulse with no ready; emg_out holds until the next frame.
module emg_bank
    import emg_pkg::*;
#(
    parameter int NCH = EMG_NCH,
    parameter int CW  = EMG_CW,
    parameter int DW  = EMG_DW,
    parameter int AW  = EMG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*CW-1:0] i_spk_cnt,
    input  logic              i_valid,
    input  logic [3:0]        i_gain_shift,
    input  logic [2:0]        i_lp_shift,
    input  logic [3:0]        i_hp_shift,
    input  logic              i_sat_en,
    output logic [NCH*DW-1:0] emg_out,
    output logic              o_valid,
    output logic              o_busy,
    output logic [NCH-1:0]    o_sat,
    output logic              o_overrun
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    emg_state_e           state_q;
    logic [CHW-1:0]       ch_q;
    logic [NCH*CW-1:0]    cnt_q;
    logic [3:0]           gain_q;
    logic [2:0]           ls_q;
    logic [3:0]           hs_q;
    logic                 sat_en_q;
    logic signed [AW-1:0] lp_q [NCH];
    logic signed [AW-1:0] hp_q [NCH];
    logic [DW-1:0]        stage_q [NCH];
    logic [NCH-1:0]       stage_sat_q;
    logic [NCH*DW-1:0]    emg_out_q;
    logic                 o_valid_q;
    logic [NCH-1:0]       o_sat_q;
    logic                 overrun_q;

    logic [CW-1:0]        cur_cnt;
    logic signed [AW-1:0] lp_d;
    logic signed [AW-1:0] hp_d;
    logic signed [AW-1:0] e_d;
    logic signed [63:0]   e_ext;
    logic signed [63:0]   e_clip;
    logic                 clip;
    logic [DW-1:0]        fmt;
    logic                 fmt_sat;

    assign cur_cnt = cnt_q[ch_q*CW +: CW];

    emg_filter_core #(
        .CW (CW),
        .AW (AW)
    ) u_core (
        .cnt_i  (cur_cnt),
        .lp_i   (lp_q[ch_q]),
        .hp_i   (hp_q[ch_q]),
        .gain_i (gain_q),
        .ls_i   (ls_q),
        .hs_i   (hs_q),
        .lp_o   (lp_d),
        .hp_o   (hp_d),
        .e_o    (e_d)
    );

    // Output formatting: clamp or plain truncation to DW bits.
    always_comb begin
        e_ext  = 64'(e_d);
        e_clip = emg_sat(e_ext, DW);
        clip   = (e_clip != e_ext);
        if (sat_en_q) begin
            fmt     = e_clip[DW-1:0];
            fmt_sat = clip;
        end else begin
            fmt     = e_d[DW-1:0];
            fmt_sat = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            gain_q      <= '0;
            ls_q        <= '0;
            hs_q        <= '0;
            sat_en_q    <= 1'b0;
            stage_sat_q <= '0;
            emg_out_q   <= '0;
            o_valid_q   <= 1'b0;
            o_sat_q     <= '0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                lp_q[k]    <= '0;
                hp_q[k]    <= '0;
                stage_q[k] <= '0;
            end
        end else begin
            o_valid_q <= 1'b0;
            if (i_valid && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    // Sample on the accepting edge so CAPT works from stable copies.
                    if (i_valid) begin
                        cnt_q    <= i_spk_cnt;
                        gain_q   <= i_gain_shift;
                        ls_q     <= i_lp_shift;
                        hs_q     <= i_hp_shift;
                        sat_en_q <= i_sat_en;
                        state_q  <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    ch_q    <= '0;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    lp_q[ch_q]        <= lp_d;
                    hp_q[ch_q]        <= hp_d;
                    stage_q[ch_q]     <= fmt;
                    stage_sat_q[ch_q] <= fmt_sat;
                    if (ch_q == CHW'(NCH - 1)) begin
                        // Publish on entry to DONE; the last channel bypasses
                        // its staging register, which is written this same edge.
                        for (int k = 0; k < NCH; k++) begin
                            if (k == NCH - 1) begin
                                emg_out_q[k*DW +: DW] <= fmt;
                                o_sat_q[k]            <= fmt_sat;
                            end else begin
                                emg_out_q[k*DW +: DW] <= stage_q[k];
                                o_sat_q[k]            <= stage_sat_q[k];
                            end
                        end
                        o_valid_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        ch_q <= ch_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign emg_out   = emg_out_q;
    assign o_valid   = o_valid_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_sat     = o_sat_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_emg_bank.sv
module tb_emg_bank;

    localparam int NCH = 4;
    localparam int CW  = 9;
    localparam int DW  = 18;
    localparam int AW  = 36;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NCH*CW-1:0] i_spk_cnt;
    logic              i_valid;
    logic [3:0]        i_gain_shift;
    logic [2:0]        i_lp_shift;
    logic [3:0]        i_hp_shift;
    logic              i_sat_en;
    logic [NCH*DW-1:0] emg_out;
    logic              o_valid;
    logic              o_busy;
    logic [NCH-1:0]    o_sat;
    logic              o_overrun;

    emg_bank #(.NCH(NCH), .CW(CW), .DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_spk_cnt    (i_spk_cnt),
        .i_valid      (i_valid),
        .i_gain_shift (i_gain_shift),
        .i_lp_shift   (i_lp_shift),
        .i_hp_shift   (i_hp_shift),
        .i_sat_en     (i_sat_en),
        .emg_out      (emg_out),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_sat        (o_sat),
        .o_overrun    (o_overrun)
    );

    int checks = 0;
    int errors = 0;

    int cfg_gain;
    int cfg_ls;
    int cfg_hs;
    int cfg_sat;

    // reference filter state, one entry per channel
    longint m_lp [NCH];
    longint m_hp [NCH];
    longint m_e  [NCH];
    logic   m_sat[NCH];

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] out_ch(input int k);
        logic [DW-1:0] s;
        s = emg_out[k*DW +: DW];
        return 64'($signed(s));
    endfunction

    function automatic logic [NCH*CW-1:0] pk(input int c0, input int c1,
                                             input int c2, input int c3);
        return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_lp[k]  = 0;
            m_hp[k]  = 0;
            m_e[k]   = 0;
            m_sat[k] = 1'b0;
        end
    endtask

    task automatic model_frame(input logic [NCH*CW-1:0] cnts);
        longint stim;
        longint e;
        logic [DW-1:0] t;
        for (int k = 0; k < NCH; k++) begin
            stim    = longint'(cnts[k*CW +: CW]) << cfg_gain;
            m_hp[k] = m_hp[k] + (stim >>> cfg_hs) - (m_hp[k] >>> cfg_hs);
            m_lp[k] = m_lp[k] - (m_lp[k] >>> cfg_ls) + (stim >>> cfg_ls);
            e       = m_lp[k] - m_hp[k];
            if (cfg_sat != 0) begin
                if (e > 131071) begin
                    m_e[k] = 131071;  m_sat[k] = 1'b1;
                end else if (e < -131072) begin
                    m_e[k] = -131072; m_sat[k] = 1'b1;
                end else begin
                    m_e[k] = e;       m_sat[k] = 1'b0;
                end
            end else begin
                t        = e[DW-1:0];
                m_e[k]   = longint'($signed(t));
                m_sat[k] = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input string tag);
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("%s_ch%0d", tag, k), out_ch(k), m_e[k]);
            chk($sformatf("%s_sat%0d", tag, k), 64'(o_sat[k]), 64'(m_sat[k]));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Strobe a frame; afterwards scramble every frame input so a design
    // that re-reads them mid-frame is caught. Returns at the negedge of t+1.
    task automatic send_frame(input logic [NCH*CW-1:0] cnts);
        logic [63:0] r;
        @(negedge clk);
        i_spk_cnt    = cnts;
        i_gain_shift = 4'(cfg_gain);
        i_lp_shift   = 3'(cfg_ls);
        i_hp_shift   = 4'(cfg_hs);
        i_sat_en     = (cfg_sat != 0);
        i_valid      = 1'b1;
        @(negedge clk);
        i_valid      = 1'b0;
        r            = {$urandom(), $urandom()};
        i_spk_cnt    = r[NCH*CW-1:0];
        i_gain_shift = 4'($urandom_range(0, 15));
        i_lp_shift   = 3'($urandom_range(0, 7));
        i_hp_shift   = 4'($urandom_range(0, 15));
        i_sat_en     = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for o_valid; lat is the cycle offset from the strobe.
    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (o_valid !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        model_reset();
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("%s_out%0d", tag, k), out_ch(k), 0);
        end
        chk({tag, "_valid"}, 64'(o_valid), 0);
        chk({tag, "_busy"}, 64'(o_busy), 0);
        chk({tag, "_sat"}, 64'(o_sat), 0);
        chk({tag, "_ovr"}, 64'(o_overrun), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int seen;
        logic [NCH*CW-1:0] cnt_a;

        reset        = 1'b1;
        i_valid      = 1'b0;
        i_spk_cnt    = '0;
        i_gain_shift = 4'd7;
        i_lp_shift   = 3'd2;
        i_hp_shift   = 4'd4;
        i_sat_en     = 1'b1;
        cfg_gain = 7; cfg_ls = 2; cfg_hs = 4; cfg_sat = 1;
        model_reset();

        repeat (2) @(negedge clk);
        check_outputs_zero("rst");
        reset = 1'b0;

        // Impulse: ch0 = 24 at t+6, single-cycle o_valid
        send_frame(pk(1, 0, 0, 0));
        chk("imp_busy_t1", 64'(o_busy), 1);
        wait_out(1, lat);
        chk("imp_latency", lat, 6);
        chk("imp_busy_done", 64'(o_busy), 1);
        model_frame(pk(1, 0, 0, 0));
        chk("imp_ch0_24", out_ch(0), 24);
        check_frame("imp");
        @(negedge clk);
        chk("imp_valid_pulse", 64'(o_valid), 0);
        chk("imp_busy_idle", 64'(o_busy), 0);
        chk("imp_ovr", 64'(o_overrun), 0);

        // Step on ch2, frames every 8 cycles, settles to exactly 0
        do_reset();
        for (int f = 1; f <= 200; f++) begin
            send_frame(pk(0, 0, 1, 0));
            wait_out(1, lat);
            model_frame(pk(0, 0, 1, 0));
            chk($sformatf("step_f%0d", f), out_ch(2), m_e[2]);
            if (f == 1) chk("step_f1_24", out_ch(2), 24);
            if (f == 2) chk("step_f2_40", out_ch(2), 40);
            if (f == 3) chk("step_f3_51", out_ch(2), 51);
            if (f == 200) begin
                chk("step_f200_zero", out_ch(2), 0);
                chk("step_f200_ch0", out_ch(0), 0);
            end
            @(negedge clk);
        end
        chk("step_ovr", 64'(o_overrun), 0);

        // Channel independence at minimum spacing NCH+3 = 7 cycles
        do_reset();
        for (int f = 1; f <= 10; f++) begin
            send_frame(pk(1, 2, 3, 4));
            wait_out(1, lat);
            model_frame(pk(1, 2, 3, 4));
            if (f == 1) begin
                chk("ind_ch0", out_ch(0), 24);
                chk("ind_ch1", out_ch(1), 48);
                chk("ind_ch2", out_ch(2), 72);
                chk("ind_ch3", out_ch(3), 96);
            end
            check_frame($sformatf("ind_f%0d", f));
        end
        chk("ind_min_spacing_ovr", 64'(o_overrun), 0);

        // Saturation on / off
        do_reset();
        cfg_gain = 15;
        send_frame(pk(511, 0, 0, 0));
        wait_out(1, lat);
        model_frame(pk(511, 0, 0, 0));
        chk("sat_on_ch0", out_ch(0), 131071);
        chk("sat_on_flag0", 64'(o_sat[0]), 1);
        chk("sat_on_flag1", 64'(o_sat[1]), 0);
        check_frame("sat_on");
        do_reset();
        cfg_sat = 0;
        send_frame(pk(511, 0, 0, 0));
        wait_out(1, lat);
        model_frame(pk(511, 0, 0, 0));
        chk("sat_off_ch0", out_ch(0), -6144);
        chk("sat_off_flag0", 64'(o_sat[0]), 0);
        check_frame("sat_off");
        cfg_gain = 7;
        cfg_sat  = 1;

        // Overrun: second strobe at t+3 with different counts is ignored
        do_reset();
        cnt_a = pk(1, 2, 0, 5);
        send_frame(cnt_a);
        @(negedge clk);
        send_frame(pk(100, 7, 9, 33));
        chk("ovr_set", 64'(o_overrun), 1);
        wait_out(4, lat);
        chk("ovr_latency", lat, 6);
        model_frame(cnt_a);
        check_frame("ovr");
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_valid === 1'b1) seen++;
        end
        chk("ovr_no_restart", seen, 0);
        chk("ovr_sticky", 64'(o_overrun), 1);

        // Strobe in the DONE cycle is an overrun and starts nothing
        do_reset();
        send_frame(pk(1, 0, 0, 0));
        wait_out(1, lat);
        chk("done_ovr_pre", 64'(o_overrun), 0);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        chk("done_ovr_set", 64'(o_overrun), 1);
        chk("done_ovr_idle", 64'(o_busy), 0);

        // Reset mid-frame at t+3 clears everything, no o_valid
        do_reset();
        send_frame(pk(1, 0, 0, 0));
        wait_out(1, lat);
        send_frame(pk(1, 1, 1, 1));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs_zero("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_valid === 1'b1) seen++;
        end
        chk("mid_rst_no_valid", seen, 0);
        chk("mid_rst_busy", 64'(o_busy), 0);
        send_frame(pk(1, 0, 0, 0));
        wait_out(1, lat);
        chk("mid_rst_latency", lat, 6);
        chk("mid_rst_imp_24", out_ch(0), 24);
        model_frame(pk(1, 0, 0, 0));
        check_frame("mid_rst_imp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
